// File: rtl/netbus_frame_arbiter.sv
// Frame-aware round-robin arbiter feeding the single NetBus FIFO write port.
// Optional per-frame beat limit with ABORT pulse: define NETBUS_ARB_FRAME_LIMIT_EN.

module netbus_arb_port #(
  parameter int W = 50
)(
  input  logic         i_grant,
  input  logic         i_lock,
  input  logic         i_valid,
  input  logic         i_m_ready,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  // Each slice contributes only while it owns the lock, so the top can OR-reduce.
  assign o_ready = i_lock & i_grant & i_m_ready;
  assign o_valid = i_lock & i_grant & i_valid;
  assign o_data  = i_grant ? i_data : '0;
endmodule

module netbus_frame_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_PORTS  = 4,
  parameter int PTR_W      = 4
`ifdef NETBUS_ARB_FRAME_LIMIT_EN
  , parameter int MAX_BEATS = 64
`endif
)(
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic [NUM_PORTS*(DATA_WIDTH*9+14)-1:0] S_DATA,
  input  logic [NUM_PORTS-1:0]                   S_VALID,
  output logic [NUM_PORTS-1:0]                   S_READY,
  output logic [DATA_WIDTH*9+14-1:0]             M_DATA,
  output logic                                   M_VALID,
  input  logic                                   M_READY,
  output logic [NUM_PORTS-1:0]                   GRANT,
  output logic                                   BUSY
`ifdef NETBUS_ARB_FRAME_LIMIT_EN
  , output logic                                 ABORT
`endif
);
  localparam int W = DATA_WIDTH*9+14;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [PTR_W-1:0]     r_gidx;
  logic [PTR_W-1:0]     r_ptr;

  logic [NUM_PORTS-1:0][W-1:0] w_s_data;
  logic [NUM_PORTS-1:0][W-1:0] w_port_data;
  logic [NUM_PORTS-1:0]        w_port_valid;
  logic [NUM_PORTS-1:0]        w_port_ready;
  logic [W-1:0]                w_sel_data;
  logic                        w_lock;
  logic                        w_xfer;
  logic                        w_last;
  logic                        w_pick_found;
  logic [NUM_PORTS-1:0]        w_pick_oh;
  logic [PTR_W-1:0]            w_pick_idx;
  logic [PTR_W-1:0]            w_ptr_next;

  assign w_s_data = S_DATA;
  // Reset gates the data path so nothing is accepted in the cycle reset is applied.
  assign w_lock   = (r_state == ST_LOCK) && !RESET;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      netbus_arb_port #(.W(W)) u_port (
        .i_grant   (r_grant[gi]),
        .i_lock    (w_lock),
        .i_valid   (S_VALID[gi]),
        .i_m_ready (M_READY),
        .i_data    (w_s_data[gi]),
        .o_ready   (w_port_ready[gi]),
        .o_valid   (w_port_valid[gi]),
        .o_data    (w_port_data[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_sel_data = w_sel_data | w_port_data[i];
  end

  assign S_READY = w_port_ready;
  assign M_VALID = |w_port_valid;
  assign w_xfer  = M_VALID & M_READY;
  assign GRANT   = r_grant;
  assign BUSY    = (r_state == ST_LOCK);

`ifdef NETBUS_ARB_FRAME_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BEATS+1);
  logic [CNT_W-1:0] r_beats;
  logic             w_force;

  assign w_force = w_lock && (r_beats == CNT_W'(MAX_BEATS-1));
  assign M_DATA  = w_lock ? {w_sel_data[W-1:1], w_sel_data[0] | w_force} : '0;
  assign ABORT   = w_xfer & w_force & ~w_sel_data[0];

  always_ff @(posedge CLK) begin
    if (RESET || r_state == ST_IDLE) r_beats <= '0;
    else if (w_xfer)                 r_beats <= r_beats + CNT_W'(1);
  end
`else
  assign M_DATA = w_lock ? w_sel_data : '0;
`endif

  assign w_last = M_DATA[0];

  // First requester at or above the pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_oh    = '0;
    w_pick_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!w_pick_found && S_VALID[i] && (((int'(r_ptr) + k) % NUM_PORTS) == i)) begin
          w_pick_found = 1'b1;
          w_pick_oh[i] = 1'b1;
          w_pick_idx   = PTR_W'(i);
        end
      end
    end
  end

  assign w_ptr_next = (r_gidx == PTR_W'(NUM_PORTS-1)) ? '0 : r_gidx + PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_state <= ST_LOCK;
            r_grant <= w_pick_oh;
            r_gidx  <= w_pick_idx;
          end
        end
        ST_LOCK: begin
          if (w_xfer && w_last) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_netbus_frame_arbiter.sv
// Scoreboard bench for netbus_frame_arbiter: directed frames, monitor checks every transfer.
module tb_netbus_frame_arbiter;
  localparam int DW = 4;
  localparam int NP = 4;
  localparam int PW = 4;
  localparam int W  = DW*9+14;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [NP*W-1:0] S_DATA = '0;
  logic [NP-1:0] S_VALID = '0;
  logic [NP-1:0] S_READY;
  logic [W-1:0]  M_DATA;
  logic          M_VALID;
  logic          M_READY = 1'b1;
  logic [NP-1:0] GRANT;
  logic          BUSY;

  always #5 CLK = ~CLK;

`ifdef NETBUS_ARB_FRAME_LIMIT_EN
  logic ABORT;
  netbus_frame_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .PTR_W(PW), .MAX_BEATS(4)) dut (
    .CLK(CLK), .RESET(RESET), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .GRANT(GRANT), .BUSY(BUSY),
    .ABORT(ABORT));
`else
  netbus_frame_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .PTR_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .GRANT(GRANT), .BUSY(BUSY));
`endif

  typedef struct {
    logic [W-1:0]  data;
    logic [NP-1:0] grant;
    int            gap;
    bit            abort;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  src_q[NP][$];
  logic [NP-1:0] fired = '0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_xfer = 0;
  bit            mon_en = 1'b0;

  function automatic logic [W-1:0] beat(int p, int s, bit last);
    logic [W-1:0] b;
    b = W'(p*256 + s*2);
    b[0] = last;
    return b;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(logic [W-1:0] d, int p, int gap, bit ab);
    exp_t e;
    e.data = d; e.grant = NP'(1 << p); e.gap = gap; e.abort = ab;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(int p, logic [W-1:0] d, int gap);
    src_q[p].push_back(d);
    push_exp(d, p, gap, 1'b0);
  endtask

  task automatic send_frame(int p, int n, int gap0, int seq0);
    for (int s = 0; s < n; s++) push_beat(p, beat(p, seq0 + s, s == n-1), (s == 0) ? gap0 : 1);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d beats pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drain_idle(string name);
    drain(name);
    @(negedge CLK);
    chk({name, "_idle_busy"}, BUSY, 0);
    chk({name, "_idle_grant"}, GRANT, 0);
    chk({name, "_idle_mvalid"}, M_VALID, 0);
  endtask

  task automatic wait_grant(string name, logic [NP-1:0] g);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (GRANT === g) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_wait: grant %0h never seen, last %0h", name, g, GRANT);
    end
  endtask

  // Source model: each port presents its queue head; popped once the handshake is seen.
  initial forever begin
    @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fired[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      S_VALID[p] = (src_q[p].size() > 0);
      S_DATA[p*W +: W] = (src_q[p].size() > 0) ? src_q[p][0] : '0;
    end
  end

  // Monitor: invariants every cycle, scoreboard compare on every transfer.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      fired = S_VALID & S_READY;
      if (mon_en) begin
        chk("grant_onehot0", 64'($onehot0(GRANT)), 1);
        chk("busy_vs_grant", BUSY, |GRANT);
        chk("ready_owner_only", S_READY & ~GRANT, 0);
        if (M_VALID && M_READY) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %0h expected none", M_DATA);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", M_DATA, e.data);
            chk("xfer_grant", GRANT, e.grant);
            if (e.gap >= 0) chk("beat_gap", cyc - last_xfer, e.gap);
`ifdef NETBUS_ARB_FRAME_LIMIT_EN
            chk("abort", ABORT, e.abort);
`endif
          end
          last_xfer = cyc;
        end
`ifdef NETBUS_ARB_FRAME_LIMIT_EN
        else chk("abort_idle", ABORT, 0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    M_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b0;
    mon_en = 1'b1;

    // Reset state, then quiet bus
    repeat (10) begin
      @(negedge CLK);
      chk("rst_mvalid", M_VALID, 0);
      chk("rst_grant", GRANT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_sready", S_READY, 0);
      chk("rst_mdata", M_DATA, 0);
    end

    // All ports busy with 2-beat frames: order 0,1,2,3,0, 3 cycles per frame
    send_frame(0, 2, -1, 0);
    send_frame(1, 2, 2, 0);
    send_frame(2, 2, 2, 0);
    send_frame(3, 2, 2, 0);
    send_frame(0, 2, 2, 2);
    drain_idle("rr");

    // Port 2, 3-beat frame: grant one cycle after valid, back-to-back beats
    send_frame(2, 3, -1, 0);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge CLK);
        if (S_VALID[2]) begin seen = 1'b1; break; end
      end
      chk("p2_valid_seen", seen, 1);
    end
    @(negedge CLK);
    chk("p2_grant_latency", GRANT, 4'b0100);
    chk("p2_busy", BUSY, 1);
    drain_idle("p2");

    // Port 1 locked, FIFO full for 8 cycles while port 3 requests
    push_beat(1, beat(1, 0, 0), -1);
    push_beat(1, beat(1, 1, 0), 9);
    push_beat(1, beat(1, 2, 0), 1);
    push_beat(1, beat(1, 3, 1), 1);
    wait_grant("bp", 4'b0010);
    @(posedge CLK);
    #2;
    M_READY = 1'b0;
    push_beat(3, beat(3, 0, 1), 2);
    repeat (8) begin
      @(negedge CLK);
      chk("bp_grant", GRANT, 4'b0010);
      chk("bp_sready", S_READY, 0);
      chk("bp_mvalid", M_VALID, 1);
      chk("bp_mdata", M_DATA, beat(1, 1, 0));
    end
    @(posedge CLK);
    #2;
    M_READY = 1'b1;
    drain_idle("bp");

    // Single-beat frame: one arbitration cycle, one locked cycle
    push_beat(1, beat(1, 5, 1), -1);
    wait_grant("single", 4'b0010);
    @(negedge CLK);
    chk("single_busy", BUSY, 0);
    chk("single_grant", GRANT, 0);

    // Reset in the middle of a port-2 frame; pointer was 2, port 0 must win afterwards
    push_beat(2, beat(2, 0, 0), -1);
    push_beat(2, beat(2, 1, 0), 1);
    src_q[2].push_back(beat(2, 2, 0));
    src_q[2].push_back(beat(2, 3, 1));
    wait_grant("mrst", 4'b0100);
    @(posedge CLK);
    #2;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    push_beat(0, beat(0, 0, 0), -1);
    push_beat(0, beat(0, 1, 1), 1);
    push_exp(beat(2, 2, 0), 2, 2, 1'b0);
    push_exp(beat(2, 3, 1), 2, 1, 1'b0);
    push_beat(3, beat(3, 1, 1), 2);
    @(negedge CLK);
    chk("mrst_mvalid", M_VALID, 0);
    chk("mrst_sready", S_READY, 0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    @(negedge CLK);
    chk("mrst_idle_grant", GRANT, 0);
    chk("mrst_idle_busy", BUSY, 0);
    @(negedge CLK);
    chk("mrst_winner", GRANT, 4'b0001);
    drain_idle("mrst");

`ifdef NETBUS_ARB_FRAME_LIMIT_EN
    // Port 0 streams 6 non-last beats with MAX_BEATS=4; beat 4 is forced last
    push_beat(0, beat(0, 0, 0), -1);
    push_beat(0, beat(0, 1, 0), 1);
    push_beat(0, beat(0, 2, 0), 1);
    src_q[0].push_back(beat(0, 3, 0));
    push_exp(beat(0, 3, 1), 0, 1, 1'b1);
    push_beat(1, beat(1, 7, 1), 2);
    src_q[0].push_back(beat(0, 4, 0));
    src_q[0].push_back(beat(0, 5, 0));
    push_exp(beat(0, 4, 0), 0, 2, 1'b0);
    push_exp(beat(0, 5, 0), 0, 1, 1'b0);
    drain("limit");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/netbus_frame_arbiter.md
Name: netbus_frame_arbiter

Overview:
- N-input, frame-aware round-robin arbiter that shares the single write port of a NetBus asynchronous FIFO.
- Sits in the write-clock domain. Its master side connects to FIFO WDATA/WVALID/WREADY.
- A grant is held for a whole frame. A frame ends on the beat where data bit 0 (last flag) = 1, so beats from different ports never interleave inside the FIFO.

Parameters:
- DATA_WIDTH, 4, NetBus lane count. Beat width W = DATA_WIDTH*9+14.
- NUM_PORTS, 4, number of requesters. Legal range 2..16.
- PTR_W, 4, width of the round-robin pointer. Must satisfy 2^PTR_W >= NUM_PORTS.

Ports:
- CLK  in  1  single clock (FIFO write clock).
- RESET  in  1  synchronous, active-high reset.
- S_DATA  in  NUM_PORTS*W  requester beats. Port i occupies bits [i*W +: W]. Bit 0 of each beat = last flag.
- S_VALID  in  NUM_PORTS  per-port valid.
- S_READY  out  NUM_PORTS  per-port ready.
- M_DATA  out  W  beat to FIFO WDATA.
- M_VALID  out  1  to FIFO WVALID.
- M_READY  in  1  from FIFO WREADY.
- GRANT  out  NUM_PORTS  one-hot current owner. All zeros when idle.
- BUSY  out  1  1 while a frame is locked.

Behaviour:
- Reset (sampled on CLK rising edge while RESET=1):
  - state=IDLE, GRANT=0, BUSY=0, M_VALID=0, S_READY=0, M_DATA=0.
  - Round-robin pointer = 0, so port 0 has highest priority first.
- FSM state IDLE:
  - M_VALID=0, all S_READY=0.
  - If any S_VALID is set, pick the first set port searching upward from the pointer, wrapping modulo NUM_PORTS.
  - Register the pick into GRANT and go to LOCK. This costs one arbitration cycle, with no beat transferred in it.
- FSM state LOCK (g = granted index):
  - M_DATA = S_DATA[g], M_VALID = S_VALID[g], S_READY[g] = M_READY. All other S_READY = 0.
  - This path is combinational, so a beat passes with zero latency.
  - A transfer happens when M_VALID & M_READY.
  - A transfer with bit0=1 returns the FSM to IDLE and sets pointer = (g+1) mod NUM_PORTS.
  - A transfer with bit0=0 keeps LOCK.
- Steady-state throughput: one frame per (beats + 1) cycles.
- Backpressure: if M_READY=0 (FIFO full), the grant holds indefinitely. There is no timeout unless the optional feature is enabled.
- If S_VALID[g] drops mid-frame, the grant holds. The arbiter waits for the owner and does not re-arbitrate mid-frame.
- A single-beat frame (bit0=1 on the first beat) is legal: one IDLE cycle, then one LOCK cycle.
- Requests that arrive while in LOCK are ignored until IDLE. Non-owner S_VALID never affects M_*.
- Pointer wrap: after g = NUM_PORTS-1, the pointer becomes 0.
- Reset asserted mid-frame: immediate return to IDLE on that edge.
  - The partial frame is abandoned. The FIFO is reset in the same domain.
  - No beat is accepted in the reset cycle, because S_READY=0 once reset takes effect.
- GRANT is always one-hot or zero. BUSY equals (state==LOCK).

Optional Feature:
- Macro: NETBUS_ARB_FRAME_LIMIT_EN.
- When defined:
  - Adds parameter MAX_BEATS (default 64) and output port ABORT (1 bit, a pulse).
  - A beat counter resets on grant and increments on each transfer in LOCK.
  - If MAX_BEATS beats transfer without bit0=1, the MAX_BEATS-th beat is forced to bit0=1 on M_DATA, which closes the frame in the FIFO.
  - ABORT pulses for one cycle on that transfer, then the FSM returns to IDLE with the pointer advanced.
  - The remaining beats of that frame on the owner port are not accepted until it wins arbitration again.
- When undefined: no counter, no ABORT port, frames are unbounded.

Test Plan:
- Reset, then S_VALID=4'b0000 for 10 cycles -> M_VALID=0, GRANT=0, BUSY=0, S_READY=0 throughout.
- Port 2 sends a 3-beat frame (bit0 = 0,0,1) with M_READY=1 held -> GRANT=4'b0100 one cycle after S_VALID. Three consecutive M_DATA beats match. IDLE on the cycle after the last beat.
- All four ports valid continuously, each sending 2-beat frames -> grant order 0,1,2,3,0. Each frame takes 3 cycles. No interleaving on M_DATA.
- Port 1 locked and M_READY=0 for 8 cycles mid-frame while port 3 is valid -> GRANT stays 4'b0010, S_READY[3]=0. Transfer resumes when M_READY=1.
- RESET pulsed high for 1 cycle on beat 2 of a 4-beat frame -> the next cycle shows IDLE, GRANT=0, pointer=0. Port 0 wins the next arbitration when valid.
- With NETBUS_ARB_FRAME_LIMIT_EN and MAX_BEATS=4, port 0 streams 6 beats with bit0=0 -> beat 4 is emitted with bit0=1 and ABORT pulses once. GRANT then moves to the next valid port.
